// File: rtl/panda_load_sequencer_pkg.sv
// rtl/panda_load_sequencer_pkg.sv - shared types and region codes for the PANDA preload sequencer
package panda_load_sequencer_pkg;

    localparam int PANDA_NB_REGION = 7;

    // Region order doubles as the demux select code; NULL parks the demux
    localparam logic [2:0] PANDA_FSM_SEL_CONFIG   = 3'd0;
    localparam logic [2:0] PANDA_FSM_SEL_INSTR    = 3'd1;
    localparam logic [2:0] PANDA_FSM_SEL_LUT      = 3'd2;
    localparam logic [2:0] PANDA_FSM_SEL_SPARSITY = 3'd3;
    localparam logic [2:0] PANDA_FSM_SEL_ACT      = 3'd4;
    localparam logic [2:0] PANDA_FSM_SEL_WCONV    = 3'd5;
    localparam logic [2:0] PANDA_FSM_SEL_WFC      = 3'd6;
    localparam logic [2:0] PANDA_FSM_SEL_NULL     = 3'd7;

    typedef enum logic [2:0] {
        SEQ_IDLE   = 3'd0,
        SEQ_SELECT = 3'd1,
        SEQ_ISSUE  = 3'd2,
        SEQ_STREAM = 3'd3,
        SEQ_DONE   = 3'd4
    } panda_seq_state_t;

endpackage

// File: rtl/panda_load_sequencer_if.sv
// rtl/panda_load_sequencer_if.sv - streamer request, beat stream and memory demux signals
interface panda_load_sequencer_if #(
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 16,
    parameter int AMEM_AW = 16
) ();

    logic               src_req_o;
    logic [ADDR_W-1:0]  src_addr_o;
    logic [LEN_W-1:0]   src_len_o;
    logic               src_ready_i;
    logic               stream_valid_i;
    logic               stream_ready_o;
    logic [2:0]         mem_sel_o;
    logic               wr_en_o;
    logic [AMEM_AW-1:0] amem_addr_o;

    modport master (
        output src_req_o, src_addr_o, src_len_o, stream_ready_o,
        output mem_sel_o, wr_en_o, amem_addr_o,
        input  src_ready_i, stream_valid_i
    );

    modport slave (
        input  src_req_o, src_addr_o, src_len_o, stream_ready_o,
        input  mem_sel_o, wr_en_o, amem_addr_o,
        output src_ready_i, stream_valid_i
    );

endinterface

// File: rtl/panda_beat_counter.sv
// rtl/panda_beat_counter.sv - per-region beat count, last-beat flag and accelerator-memory address
module panda_beat_counter #(
    parameter int LEN_W   = 16,
    parameter int AMEM_AW = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               beat_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic [AMEM_AW-1:0] base_i,
    output logic               last_o,
    output logic [AMEM_AW-1:0] addr_o
);

    logic [LEN_W-1:0] count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else if (clear_i) begin
            count <= '0;
        end else if (beat_i) begin
            count <= last_o ? '0 : count + 1'b1;
        end
    end

    assign last_o = (count == len_i - 1'b1);
    // Address wraps modulo the accelerator-memory size
    assign addr_o = base_i + AMEM_AW'(count);

endmodule

// File: rtl/panda_load_sequencer.sv
// rtl/panda_load_sequencer.sv - walks the seven preload regions, issuing streamer transfers and steering beats
module panda_load_sequencer
    import panda_load_sequencer_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int LEN_W     = 16,
    parameter int AMEM_AW   = 16,
    parameter int NB_REGION = PANDA_NB_REGION
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         clear_i,
    input  logic                         start_i,
    input  logic [NB_REGION*ADDR_W-1:0]  region_daddr_i,
    input  logic [NB_REGION*LEN_W-1:0]   region_len_i,
    input  logic [NB_REGION*AMEM_AW-1:0] region_aaddr_i,
    panda_load_sequencer_if.master       bus,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam logic [2:0] ST_IDLE   = SEQ_IDLE;
    localparam logic [2:0] ST_SELECT = SEQ_SELECT;
    localparam logic [2:0] ST_ISSUE  = SEQ_ISSUE;
    localparam logic [2:0] ST_STREAM = SEQ_STREAM;
    localparam logic [2:0] ST_DONE   = SEQ_DONE;

    logic [2:0] state;
    logic [2:0] idx;

    logic [NB_REGION*ADDR_W-1:0]  daddr_q;
    logic [NB_REGION*LEN_W-1:0]   len_q;
    logic [NB_REGION*AMEM_AW-1:0] aaddr_q;

    logic [ADDR_W-1:0]  cur_daddr;
    logic [LEN_W-1:0]   cur_len;
    logic [AMEM_AW-1:0] cur_aaddr;
    logic [AMEM_AW-1:0] beat_addr;
    logic               beat;
    logic               last_beat;
    logic               last_region;
    logic               cnt_clear;

    assign cur_daddr   = daddr_q[32'(idx)*ADDR_W +: ADDR_W];
    assign cur_len     = len_q[32'(idx)*LEN_W +: LEN_W];
    assign cur_aaddr   = aaddr_q[32'(idx)*AMEM_AW +: AMEM_AW];
    assign last_region = (idx == 3'(NB_REGION - 1));
    assign beat        = (state == ST_STREAM) && bus.stream_valid_i;
    // Holding the counter at zero outside STREAM also discards an aborted transfer
    assign cnt_clear   = clear_i || (state != ST_STREAM);

    panda_beat_counter #(
        .LEN_W   (LEN_W),
        .AMEM_AW (AMEM_AW)
    ) u_beat_counter (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (cnt_clear),
        .beat_i  (beat),
        .len_i   (cur_len),
        .base_i  (cur_aaddr),
        .last_o  (last_beat),
        .addr_o  (beat_addr)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            idx     <= PANDA_FSM_SEL_CONFIG;
            daddr_q <= '0;
            len_q   <= '0;
            aaddr_q <= '0;
        end else if (clear_i) begin
            state <= ST_IDLE;
            idx   <= PANDA_FSM_SEL_CONFIG;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        daddr_q <= region_daddr_i;
                        len_q   <= region_len_i;
                        aaddr_q <= region_aaddr_i;
                        idx     <= PANDA_FSM_SEL_CONFIG;
                        state   <= ST_SELECT;
                    end
                end
                ST_SELECT: begin
                    if (cur_len != '0) begin
                        state <= ST_ISSUE;
                    end else if (last_region) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                ST_ISSUE: begin
                    if (bus.src_ready_i) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (beat && last_beat) begin
                        if (last_region) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= ST_SELECT;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.src_req_o      = (state == ST_ISSUE);
    assign bus.src_addr_o     = (state == ST_ISSUE) ? cur_daddr : '0;
    assign bus.src_len_o      = (state == ST_ISSUE) ? cur_len : '0;
    assign bus.stream_ready_o = (state == ST_STREAM);
    assign bus.mem_sel_o      = (state == ST_STREAM) ? idx : PANDA_FSM_SEL_NULL;
    assign bus.wr_en_o        = beat;
    assign bus.amem_addr_o    = (state == ST_STREAM) ? beat_addr : '0;
    assign busy_o             = (state != ST_IDLE);
    assign done_o             = (state == ST_DONE);

endmodule

// File: tb/tb_panda_load_sequencer.sv
// tb/tb_panda_load_sequencer.sv - self-checking bench for the PANDA preload sequencer
module tb_panda_load_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0;
    logic start = 1'b0;
    logic [7*32-1:0] region_daddr = '0;
    logic [7*16-1:0] region_len = '0;
    logic [7*16-1:0] region_aaddr = '0;
    logic busy, done;

    panda_load_sequencer_if #(.ADDR_W(32), .LEN_W(16), .AMEM_AW(16)) bus ();

    panda_load_sequencer #(.ADDR_W(32), .LEN_W(16), .AMEM_AW(16), .NB_REGION(7)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clear_i        (clear),
        .start_i        (start),
        .region_daddr_i (region_daddr),
        .region_len_i   (region_len),
        .region_aaddr_i (region_aaddr),
        .bus            (bus.master),
        .busy_o         (busy),
        .done_o         (done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; logic [15:0] len; } req_t;
    typedef struct { logic [2:0] sel; logic [15:0] addr; } wr_t;
    typedef struct {
        logic [6:0][15:0] len;
        logic [6:0][31:0] daddr;
        logic [6:0][15:0] aaddr;
        int dly; int vm; int nreq; int nwr; int first; int reqcyc; int lat;
    } vec_t;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    req_t exp_req[$], obs_req[$];
    wr_t  exp_wr[$], obs_wr[$];
    req_t mon_req;
    wr_t  mon_wr;
    int done_cnt = 0, done_cyc = 0, first_req_cyc = -1, req_cycles = 0, start_cyc = 0;
    logic holding = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [15:0] hold_len = '0;
    int rdy_delay = 0, vmode = 0, rdy_wait = 0;
    logic tog = 1'b0;
    logic [15:0] cfg_len[7];
    logic [15:0] cfg_aaddr[7];
    logic [31:0] cfg_daddr[7];
    vec_t vecs[5];
    logic [15:0] wrap_exp[4];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Streamer model: request acceptance after rdy_delay cycles, beat validity per vmode
    always @(posedge clk) begin
        #1;
        if (bus.src_req_o) begin
            bus.src_ready_i = (rdy_wait >= rdy_delay);
            rdy_wait++;
        end else begin
            bus.src_ready_i = 1'b0;
            rdy_wait = 0;
        end
        case (vmode)
            0: bus.stream_valid_i = 1'b1;
            1: begin bus.stream_valid_i = tog; tog = ~tog; end
            default: bus.stream_valid_i = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("wr_en_gating", bus.wr_en_o, bus.stream_ready_o & bus.stream_valid_i);
            if (!bus.stream_ready_o) chk("mem_sel_null", bus.mem_sel_o, 7);
            if (bus.src_req_o) begin
                req_cycles++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (holding) begin
                    chk("req_addr_stable", bus.src_addr_o, hold_addr);
                    chk("req_len_stable", bus.src_len_o, hold_len);
                end
                if (bus.src_ready_i) begin
                    mon_req.addr = bus.src_addr_o;
                    mon_req.len  = bus.src_len_o;
                    obs_req.push_back(mon_req);
                    holding = 1'b0;
                end else begin
                    holding   = 1'b1;
                    hold_addr = bus.src_addr_o;
                    hold_len  = bus.src_len_o;
                end
            end else begin
                holding = 1'b0;
            end
            if (bus.wr_en_o) begin
                mon_wr.sel  = bus.mem_sel_o;
                mon_wr.addr = bus.amem_addr_o;
                obs_wr.push_back(mon_wr);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic load_cfg();
        for (int r = 0; r < 7; r++) begin
            region_len[r*16 +: 16]   = cfg_len[r];
            region_daddr[r*32 +: 32] = cfg_daddr[r];
            region_aaddr[r*16 +: 16] = cfg_aaddr[r];
        end
        obs_req.delete();
        obs_wr.delete();
        done_cnt = 0;
        first_req_cyc = -1;
        req_cycles = 0;
    endtask

    task automatic run_case(input string tag, input int nreq, input int nwr,
                            input int first, input int reqcyc, input int lat);
        req_t er;
        wr_t ew;
        load_cfg();
        exp_req.delete();
        exp_wr.delete();
        for (int r = 0; r < 7; r++) begin
            if (cfg_len[r] != 0) begin
                er.addr = cfg_daddr[r];
                er.len  = cfg_len[r];
                exp_req.push_back(er);
                for (int k = 0; k < int'(cfg_len[r]); k++) begin
                    ew.sel  = 3'(r);
                    ew.addr = 16'(int'(cfg_aaddr[r]) + k);
                    exp_wr.push_back(ew);
                end
            end
        end
        @(posedge clk); #1 start = 1'b1; start_cyc = cyc;
        @(posedge clk); #1 start = 1'b0;
        region_daddr = {7{$urandom()}};
        region_len   = {7{16'($urandom())}};
        region_aaddr = {7{16'($urandom())}};
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_done_seen"}, done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_idle_after"}, busy, 0);
        chk({tag, "_nreq_model"}, obs_req.size(), exp_req.size());
        chk({tag, "_nwr_model"}, obs_wr.size(), exp_wr.size());
        if (nreq >= 0) chk({tag, "_nreq"}, obs_req.size(), nreq);
        if (nwr >= 0) chk({tag, "_nwr"}, obs_wr.size(), nwr);
        for (int i = 0; i < obs_req.size() && i < exp_req.size(); i++) begin
            chk({tag, "_req_addr"}, obs_req[i].addr, exp_req[i].addr);
            chk({tag, "_req_len"}, obs_req[i].len, exp_req[i].len);
        end
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
            chk({tag, "_wr_sel"}, obs_wr[i].sel, exp_wr[i].sel);
            chk({tag, "_wr_addr"}, obs_wr[i].addr, exp_wr[i].addr);
        end
        if (first >= 0) chk({tag, "_first_req_lat"}, first_req_cyc - start_cyc, first);
        if (reqcyc >= 0) chk({tag, "_req_cycles"}, req_cycles, reqcyc);
        if (lat >= 0) chk({tag, "_done_lat"}, done_cyc - start_cyc, lat);
    endtask

    task automatic set_full_cfg();
        for (int r = 0; r < 7; r++) begin
            cfg_len[r]   = 16'd4;
            cfg_daddr[r] = 32'(r * 'h100);
            cfg_aaddr[r] = 16'(r * 'h40);
        end
        rdy_delay = 0;
        vmode = 0;
    endtask

    task automatic wait_writes(input string tag, input int n);
        for (int k = 0; k < 200 && obs_wr.size() < n; k++) begin
            @(negedge clk); #1;
        end
        chk({tag, "_beats_before_abort"}, obs_wr.size(), n);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.src_ready_i = 1'b0;
        bus.stream_valid_i = 1'b0;
        wrap_exp[0] = 16'hFFFE; wrap_exp[1] = 16'hFFFF;
        wrap_exp[2] = 16'h0000; wrap_exp[3] = 16'h0001;

        for (int i = 0; i < 5; i++) begin
            vecs[i].len = '0; vecs[i].daddr = '0; vecs[i].aaddr = '0;
            vecs[i].dly = 0; vecs[i].vm = 0;
        end
        for (int r = 0; r < 7; r++) begin
            vecs[0].len[r] = 16'd4;
            vecs[0].daddr[r] = 32'(r * 'h100);
            vecs[0].aaddr[r] = 16'(r * 'h40);
        end
        vecs[0].nreq = 7; vecs[0].nwr = 28; vecs[0].first = 2; vecs[0].reqcyc = 7; vecs[0].lat = 43;
        vecs[1].len[4] = 16'd3; vecs[1].daddr[4] = 32'h0000_4000; vecs[1].aaddr[4] = 16'h0200; vecs[1].dly = 5;
        vecs[1].nreq = 1; vecs[1].nwr = 3; vecs[1].first = 6; vecs[1].reqcyc = 6; vecs[1].lat = 17;
        vecs[2].nreq = 0; vecs[2].nwr = 0; vecs[2].first = -1; vecs[2].reqcyc = 0; vecs[2].lat = 8;
        vecs[3].len[2] = 16'd2; vecs[3].daddr[2] = 32'h0000_8000; vecs[3].aaddr[2] = 16'h0010; vecs[3].vm = 1;
        vecs[3].nreq = 1; vecs[3].nwr = 2; vecs[3].first = 4; vecs[3].reqcyc = 1; vecs[3].lat = -1;
        vecs[4].len[6] = 16'd4; vecs[4].daddr[6] = 32'h0000_C000; vecs[4].aaddr[6] = 16'hFFFE;
        vecs[4].nreq = 1; vecs[4].nwr = 4; vecs[4].first = 8; vecs[4].reqcyc = 1; vecs[4].lat = 13;

        #1 rst = 1'b1;
        #1;
        chk("rst_src_req", bus.src_req_o, 0);
        chk("rst_src_len", bus.src_len_o, 0);
        chk("rst_wr_en", bus.wr_en_o, 0);
        chk("rst_mem_sel", bus.mem_sel_o, 7);
        chk("rst_stream_ready", bus.stream_ready_o, 0);
        chk("rst_amem_addr", bus.amem_addr_o, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            for (int r = 0; r < 7; r++) begin
                cfg_len[r] = vecs[i].len[r];
                cfg_daddr[r] = vecs[i].daddr[r];
                cfg_aaddr[r] = vecs[i].aaddr[r];
            end
            rdy_delay = vecs[i].dly;
            vmode = vecs[i].vm;
            run_case($sformatf("vec%0d", i), vecs[i].nreq, vecs[i].nwr,
                     vecs[i].first, vecs[i].reqcyc, vecs[i].lat);
            if (i == 0 && obs_wr.size() >= 24) begin
                for (int k = 0; k < 4; k++) begin
                    chk("vec0_r5_addr", obs_wr[20+k].addr, 16'h0140 + 16'(k));
                    chk("vec0_r5_sel", obs_wr[20+k].sel, 5);
                end
            end
            if (i == 4 && obs_wr.size() >= 4) begin
                for (int k = 0; k < 4; k++) chk("vec4_wrap_addr", obs_wr[k].addr, wrap_exp[k]);
            end
        end

        // Asynchronous reset in the middle of region 0's stream
        set_full_cfg();
        load_cfg();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_writes("rst_abort", 2);
        @(posedge clk); #1 rst = 1'b1;
        #1;
        chk("rst_abort_mem_sel", bus.mem_sel_o, 7);
        chk("rst_abort_busy", busy, 0);
        chk("rst_abort_wr_en", bus.wr_en_o, 0);
        chk("rst_abort_stream_ready", bus.stream_ready_o, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("rst_abort_no_done", done_cnt, 0);
        chk("rst_abort_writes", obs_wr.size(), 2);

        // Soft clear with a simultaneous start: clear wins, the run stops
        load_cfg();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_writes("clr_abort", 2);
        @(posedge clk); #1 clear = 1'b1; start = 1'b1;
        @(posedge clk); #1 clear = 1'b0; start = 1'b0;
        chk("clr_abort_idle_next", busy, 0);
        repeat (5) @(negedge clk);
        #1;
        chk("clr_abort_still_idle", busy, 0);
        chk("clr_abort_no_done", done_cnt, 0);
        chk("clr_abort_reqs", obs_req.size(), 1);
        chk("clr_abort_writes", obs_wr.size(), 3);

        set_full_cfg();
        run_case("restart", 7, 28, 2, 7, 43);

        for (int n = 0; n < 20; n++) begin
            for (int r = 0; r < 7; r++) begin
                cfg_len[r]   = ($urandom_range(0, 9) < 3) ? 16'd0 : 16'($urandom_range(1, 5));
                cfg_daddr[r] = $urandom();
                cfg_aaddr[r] = 16'($urandom());
            end
            rdy_delay = $urandom_range(0, 3);
            vmode = $urandom_range(0, 2);
            run_case($sformatf("rnd%0d", n), -1, -1, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
